// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan path.
// The optional blink feature is enabled with the SEG_BLINK_EN macro.
package seg_pkg;

  localparam int SEG_MAX_DIGITS = 8;
  localparam logic [SEG_MAX_DIGITS-1:0] SEG_LES_RST = 8'hFF;

  // One full frame of display data; used for both pending and committed copies.
  typedef struct packed {
    logic [4*SEG_MAX_DIGITS-1:0] hexs;
    logic [SEG_MAX_DIGITS-1:0]   point;
    logic [SEG_MAX_DIGITS-1:0]   les;
  } seg_frame_t;

  // Frame contents after reset: all nibbles zero, no points, every digit blanked.
  function automatic seg_frame_t seg_reset_frame();
    seg_frame_t f;
    f.hexs  = '0;
    f.point = '0;
    f.les   = SEG_LES_RST;
    return f;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_prescaler.sv
// Free-running prescaler: counts 0..PRESCALE-1 and flags the last count.
module seg_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pcnt;

  // Wrap the counter on the last count so each slot is exactly PRESCALE cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (pcnt == LAST) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  assign tick = (pcnt == LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan generator and double-buffered display data holder for the
// 7-segment multiplexer. New data is written through a one-deep
// valid/ready port and committed only at a frame boundary.
// Optional feature: SEG_BLINK_EN adds blink_mask and a frame counter
// that ORs the mask into LES on alternate half-periods.
//
// Handshake: a write is accepted on any edge where wr_en && wr_ready;
// wr_ready is ~pend_valid, so it never depends on wr_en. A write seen
// while wr_ready is low is dropped and the pending data is untouched.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int PRESCALE   = 50000,
  parameter int NUM_DIGITS = 4
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_W    = 5
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [4*SEG_MAX_DIGITS-1:0] wr_hexs,
  input  logic [SEG_MAX_DIGITS-1:0]   wr_point,
  input  logic [SEG_MAX_DIGITS-1:0]   wr_les,
  output logic                        wr_ready,
`ifdef SEG_BLINK_EN
  input  logic [SEG_MAX_DIGITS-1:0]   blink_mask,
`endif
  output logic [4*SEG_MAX_DIGITS-1:0] Hexs,
  output logic [SEG_MAX_DIGITS-1:0]   point,
  output logic [SEG_MAX_DIGITS-1:0]   LES,
  output logic [2:0]                  Scan,
  output logic                        frame_start
);

  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

  logic       tick;
  logic       boundary;
  logic       commit;
  logic [2:0] scan_q;
  logic       frame_start_q;
  logic       pend_valid;
  seg_frame_t pend;
  seg_frame_t disp;

  seg_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign boundary = tick && (scan_q == LAST_DIGIT);
  assign commit   = boundary && pend_valid;

  // Step the digit index each slot; pulse frame_start as Scan returns to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q        <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= boundary;
      if (tick) begin
        scan_q <= boundary ? 3'd0 : scan_q + 3'd1;
      end
    end
  end

  // Pending buffer: capture only when empty, drain only at a committing boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend       <= '0;
    end else if (commit) begin
      pend_valid <= 1'b0;
    end else if (wr_en && !pend_valid) begin
      pend_valid <= 1'b1;
      pend.hexs  <= wr_hexs;
      pend.point <= wr_point;
      pend.les   <= wr_les;
    end
  end

  // Committed frame: replaced only at a boundary that has pending data.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp <= seg_reset_frame();
    end else if (commit) begin
      disp <= pend;
    end
  end

`ifdef SEG_BLINK_EN
  logic [BLINK_W-1:0]        blink_cnt;
  logic [BLINK_W-1:0]        blink_cnt_nxt;
  logic [SEG_MAX_DIGITS-1:0] les_base;
  logic [SEG_MAX_DIGITS-1:0] les_q;

  assign blink_cnt_nxt = blink_cnt + 1'b1;
  assign les_base      = commit ? pend.les : disp.les;

  // Frame counter and blanked view; the phase applied is that of the frame now starting.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      les_q     <= SEG_LES_RST;
    end else if (boundary) begin
      blink_cnt <= blink_cnt_nxt;
      les_q     <= blink_cnt_nxt[BLINK_W-1] ? (les_base | blink_mask) : les_base;
    end
  end

  assign LES = les_q;
`else
  assign LES = disp.les;
`endif

  assign Hexs        = disp.hexs;
  assign point       = disp.point;
  assign Scan        = scan_q;
  assign frame_start = frame_start_q;
  assign wr_ready    = ~pend_valid;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with PRESCALE=4, NUM_DIGITS=4 (16-cycle frame).
// The reference model tracks time since reset and derives slot, frame
// boundaries and the one-deep write buffer arithmetically; each boundary
// pushes the expected display frame, popped by the monitor on frame_start.
module tb_seg_scan_ctrl;

  localparam int PRE   = 4;
  localparam int ND    = 4;
  localparam int FRAME = PRE * ND;
`ifdef SEG_BLINK_EN
  localparam int BW    = 1;
`endif
  localparam logic [47:0] RST_FRAME = {32'h0, 8'h00, 8'hFF};

  // clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_hexs = '0;
  logic [7:0]  wr_point = '0;
  logic [7:0]  wr_les = '0;
  logic        wr_ready;
`ifdef SEG_BLINK_EN
  logic [7:0]  blink_mask = '0;
`endif
  logic [31:0] Hexs;
  logic [7:0]  point;
  logic [7:0]  LES;
  logic [2:0]  Scan;
  logic        frame_start;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .PRESCALE  (PRE),
    .NUM_DIGITS(ND)
`ifdef SEG_BLINK_EN
    ,
    .BLINK_W   (BW)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_hexs    (wr_hexs),
    .wr_point   (wr_point),
    .wr_les     (wr_les),
    .wr_ready   (wr_ready),
`ifdef SEG_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .Hexs       (Hexs),
    .point      (point),
    .LES        (LES),
    .Scan       (Scan),
    .frame_start(frame_start)
  );

  // scoreboard state
  logic [47:0] exp_q[$];
  int          vectors = 0;
  int          errors  = 0;
  bit          mon_en  = 1'b0;
  logic        rst_seen = 1'b0;
  logic [47:0] cur_exp = RST_FRAME;

  // reference model state
  int          t = 0;
  bit          m_init = 1'b0;
  bit          m_pend = 1'b0;
  logic [47:0] m_pend_f = '0;
  logic [47:0] m_disp = RST_FRAME;
  int          m_frames = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0d)", name, act, exp, t);
    end
  endtask

  // driver: check visible state, drive one cycle of inputs, advance the model
  task automatic step(input bit en, input logic [31:0] h, input logic [7:0] p,
                      input logic [7:0] l, input bit r);
    logic [47:0] e;
    bit          acc;
    bit          bnd;
`ifdef SEG_BLINK_EN
    logic [7:0]  bm;
    bm = 8'($urandom_range(0, 255));
    blink_mask = bm;
`endif
    if (m_init) begin
      chk("scan", 32'(Scan), 32'((t / PRE) % ND));
      chk("wr_ready", 32'(wr_ready), 32'(!m_pend));
      chk("frame_start", 32'(frame_start), 32'((t > 0) && (t % FRAME == 0)));
    end
    rst      = r;
    wr_en    = en;
    wr_hexs  = h;
    wr_point = p;
    wr_les   = l;
    if (r) begin
      t        = 0;
      m_init   = 1'b1;
      m_pend   = 1'b0;
      m_disp   = RST_FRAME;
      m_frames = 0;
    end else if (m_init) begin
      bnd = (t % FRAME) == FRAME - 1;
      acc = en && !m_pend;
      if (bnd) begin
        if (m_pend) begin
          m_disp = m_pend_f;
          m_pend = 1'b0;
        end
        m_frames++;
        e = m_disp;
`ifdef SEG_BLINK_EN
        if ((m_frames % (1 << BW)) >= (1 << (BW - 1))) e[7:0] = e[7:0] | bm;
`endif
        exp_q.push_back(e);
      end
      if (acc) begin
        m_pend   = 1'b1;
        m_pend_f = {h, p, l};
      end
      t++;
    end
    @(negedge clk);
  endtask

  task automatic idle_until(input int target);
    while (t < target) step(1'b0, 32'h0, 8'h0, 8'h0, 1'b0);
  endtask

  // monitor: reset edges restore the reset frame, frame_start pops the next expected frame
  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_seen) begin
        cur_exp = RST_FRAME;
      end else if (frame_start) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_pop: frame_start with no expected frame (t=%0d)", t);
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
      chk("hexs", Hexs, cur_exp[47:16]);
      chk("point", 32'(point), 32'(cur_exp[15:8]));
      chk("les", 32'(LES), 32'(cur_exp[7:0]));
    end
  end

  initial begin
    @(negedge clk);
    // reset for two cycles
    step(1'b0, 32'h0, 8'h0, 8'h0, 1'b1);
    step(1'b0, 32'h0, 8'h0, 8'h0, 1'b1);
    mon_en = 1'b1;

    // basic write, write while full, commit at first boundary
    idle_until(3);
    step(1'b1, 32'h1234ABCD, 8'h5A, 8'hF0, 1'b0);
    idle_until(5);
    step(1'b1, 32'hDEADBEEF, 8'hFF, 8'h00, 1'b0);
    idle_until(20);
    step(1'b1, 32'h00005678, 8'h01, 8'h0E, 1'b0);

    // write landing on a committing boundary is dropped
    idle_until(31);
    step(1'b1, 32'hCAFEF00D, 8'hAA, 8'h55, 1'b0);
    idle_until(40);

    // reset mid-frame with data pending
    step(1'b0, 32'h0, 8'h0, 8'h0, 1'b1);
    idle_until(3);
    step(1'b1, 32'h99999999, 8'h0F, 8'h00, 1'b0);
    idle_until(9);
    step(1'b0, 32'h0, 8'h0, 8'h0, 1'b1);
    idle_until(40);

    // randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) < 30, $urandom, 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), $urandom_range(0, 199) == 0);
    end
    idle_until(t + 2 * FRAME);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
